// File: rtl/spi_rf_bridge.sv
// spi_rf_bridge: mode-0 SPI slave oversampled in clk that
// drives the regfile row port (addr/we/wdata/wmask) from frames.
module spi_rf_bridge #(
  parameter int AWIDTH = 7,
  parameter int DWIDTH = 32,
  parameter int MWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [AWIDTH-1:0] addr,
  output logic              we,
  output logic [DWIDTH-1:0] wdata,
  output logic [MWIDTH-1:0] wmask,
  input  logic [DWIDTH-1:0] rdata
);

  localparam int BW = (MWIDTH > 1) ? $clog2(MWIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(MWIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    MASK,
    DATA
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]        sclk_s;
  logic [2:0]        sel_s;
  logic [1:0]        mosi_s;
  logic [2:0]        bit_cnt;
  logic [BW-1:0]     byte_cnt;
  logic [6:0]        rx;
  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] tx;
  logic [2:0]        tx_cnt;
  logic              tx_load;
  logic              wr;

  logic              rise;
  logic              fall;
  logic              cs_on;
  logic              cs_off;
  logic              byte_done;
  logic              word_done;
  logic              shift_tx;
  logic [7:0]        rx_nx;
  logic [DWIDTH-1:0] word_nx;

  // sel_s holds the inverted chip select so reset means "deselected"
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      sel_s  <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_sclk};
      sel_s  <= {sel_s[1:0], ~spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
    end
  end

  assign rise        = sclk_s[1] & ~sclk_s[2];
  assign fall        = ~sclk_s[1] & sclk_s[2];
  assign cs_on       = sel_s[1] & ~sel_s[2];
  assign cs_off      = ~sel_s[1] & sel_s[2];
  assign spi_miso_oe = sel_s[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (cs_off) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (cs_on) state_nx = CMD;
        CMD:     if (byte_done) state_nx = MASK;
        MASK:    if (byte_done) state_nx = DATA;
        DATA:    state_nx = DATA;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_nx     = {rx, mosi_s[1]};
    byte_done = rise & ~cs_off & (state != IDLE)
              & (bit_cnt == 3'd7);
    word_done = byte_done & (state == DATA)
              & (byte_cnt == LAST);
    shift_tx  = fall & ~cs_off & (state == DATA) & ~wr;
    word_nx   = acc;
    word_nx[{byte_cnt, 3'b000} +: 8] = rx_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      we       <= 1'b0;
      wdata    <= '0;
      wmask    <= '0;
      spi_miso <= 1'b0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rx       <= '0;
      acc      <= '0;
      tx       <= '0;
      tx_cnt   <= '0;
      tx_load  <= 1'b0;
      wr       <= 1'b0;
    end else begin
      we      <= 1'b0;
      tx_load <= 1'b0;
      if (we) addr <= addr + AWIDTH'(1);
      if (tx_load) begin
        tx     <= rdata;
        tx_cnt <= '0;
      end
      if (cs_on && state == IDLE) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end
      if (cs_off) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        spi_miso <= 1'b0;
      end else begin
        if (rise && state != IDLE) begin
          rx      <= rx_nx[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          unique case (state)
            CMD: begin
              addr    <= AWIDTH'(rx_nx[6:0]);
              wr      <= rx_nx[7];
              tx_load <= ~rx_nx[7];
            end
            MASK: if (wr) wmask <= rx_nx[MWIDTH-1:0];
            DATA: begin
              acc      <= word_nx;
              byte_cnt <= (byte_cnt == LAST) ? '0
                        : byte_cnt + BW'(1);
              if (word_done && wr) begin
                wdata <= word_nx;
                we    <= 1'b1;
              end else if (word_done) begin
                addr    <= addr + AWIDTH'(1);
                tx_load <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        // falls walk the low byte MSB-first, then drop to the next byte
        if (fall) begin
          spi_miso <= shift_tx ? tx[7] : 1'b0;
          if (shift_tx) begin
            tx_cnt <= tx_cnt + 3'd1;
            if (tx_cnt == 3'd7) tx <= {8'b0, tx[DWIDTH-1:8]};
            else tx[7:0] <= {tx[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_rf_bridge.sv
// tb_spi_rf_bridge: scoreboard bench driving SPI frames into
// spi_rf_bridge against a modelled regfile.
module tb_spi_rf_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [6:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;

  logic [31:0] mem [0:127];
  assign rdata = mem[addr];

  spi_rf_bridge #(.AWIDTH(7), .DWIDTH(32), .MWIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .addr(addr),
    .we(we),
    .wdata(wdata),
    .wmask(wmask),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  wr_t        we_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] fb [0:79];
  logic [7:0] fe [0:79];
  int         fn;
  int         half = 50;
  int         checks = 0;
  int         failures = 0;
  string      tname;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : we_mon
    wr_t e;
    if (!rst && we) begin
      if (we_q.size() == 0) begin
        chk("we_unexpected", 64'(we), 64'(1'b0));
      end else begin
        e = we_q.pop_front();
        chk("we_addr", 64'(addr), 64'(e.a));
        chk("we_wdata", 64'(wdata), 64'(e.d));
        chk("we_wmask", 64'(wmask), 64'(e.m));
      end
    end
  end

  function automatic logic [7:0] model_byte(input int row,
                                            input int j);
    logic [31:0] w;
    w = mem[(row + j / 4) % 128];
    return w[8 * (j % 4) +: 8];
  endfunction

  task automatic put(input logic [7:0] d, input logic [7:0] e);
    fb[fn] = d;
    fe[fn] = e;
    fn++;
  endtask

  task automatic xfer(input logic [7:0] t, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = t[i];
      #(half);
      r[i] = spi_miso;
      spi_sclk = 1'b1;
      #(half);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input int nb);
    logic [7:0] r;
    spi_cs_n = 1'b0;
    #(half);
    for (int b = 0; b < nb; b++) begin
      miso_q.push_back(fe[b]);
      xfer(fb[b], r);
      chk($sformatf("%s_miso%0d", tname, b), 64'(r),
          64'(miso_q.pop_front()));
    end
    #(half);
    spi_cs_n = 1'b1;
    #(half * 4);
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_addr"}, 64'(addr), 64'd0);
    chk({p, "_we"}, 64'(we), 64'd0);
    chk({p, "_wdata"}, 64'(wdata), 64'd0);
    chk({p, "_wmask"}, 64'(wmask), 64'd0);
    chk({p, "_miso"}, 64'(spi_miso), 64'd0);
    chk({p, "_oe"}, 64'(spi_miso_oe), 64'd0);
  endtask

  initial begin : watchdog
    #(3000000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] w;
    logic [7:0]  r;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    #3;
    repeat (4) @(negedge clk);
    chk_reset_outs("rst0");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #3;

    tname = "wr";
    fn = 0;
    put(8'h8C, 8'h00); put(8'h0F, 8'h00);
    put(8'h78, 8'h00); put(8'h56, 8'h00);
    put(8'h34, 8'h00); put(8'h12, 8'h00);
    we_q.push_back('{a: 7'd12, d: 32'h12345678, m: 4'hF});
    send_frame(fn);
    chk("wr_pending", 64'(we_q.size()), 64'd0);

    tname = "rd";
    mem[0] = 32'h0000_00A5;
    fn = 0;
    put(8'h00, 8'h00); put(8'h00, 8'h00);
    for (int j = 0; j < 4; j++) put(8'h00, model_byte(0, j));
    send_frame(fn);
    chk("rd_wmask_kept", 64'(wmask), 64'hF);

    tname = "mwr";
    fn = 0;
    put(8'h83, 8'h00); put(8'h05, 8'h00);
    put(8'h11, 8'h00); put(8'h22, 8'h00);
    put(8'h33, 8'h00); put(8'h44, 8'h00);
    we_q.push_back('{a: 7'd3, d: 32'h44332211, m: 4'b0101});
    send_frame(fn);
    chk("mwr_pending", 64'(we_q.size()), 64'd0);

    tname = "wrap";
    fn = 0;
    put(8'hFF, 8'h00); put(8'hFF, 8'h0);
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++) put(w[8 * j +: 8], 8'h00);
      we_q.push_back('{a: 7'(127 + k), d: w, m: 4'hF});
    end
    send_frame(fn);
    chk("wrap_pending", 64'(we_q.size()), 64'd0);

    tname = "abort";
    fn = 0;
    put(8'h85, 8'h00); put(8'h0F, 8'h00);
    put(8'hAA, 8'h00); put(8'hBB, 8'h00);
    send_frame(fn);
    @(negedge clk);
    chk("abort_addr", 64'(addr), 64'd5);

    spi_cs_n = 1'b0;
    #(half);
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'b1;
      #(half);
      spi_sclk = 1'b1;
      #(half);
      spi_sclk = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst1");
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk_reset_outs("rst2");
    #3;

    tname = "post";
    fn = 0;
    put(8'h89, 8'h00); put(8'hFC, 8'h00);
    w = 32'hCAFE_0123;
    for (int j = 0; j < 4; j++) put(w[8 * j +: 8], 8'h00);
    we_q.push_back('{a: 7'd9, d: w, m: 4'hC});
    send_frame(fn);
    chk("post_pending", 64'(we_q.size()), 64'd0);

    tname = "stress";
    half = 40;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    #($urandom_range(1, 9));
    fn = 0;
    put(8'h78, 8'h00);
    r = 8'($urandom_range(1, 255));
    put(r, 8'h00);
    for (int j = 0; j < 64; j++)
      put(8'($urandom), model_byte(120, j));
    send_frame(fn);
    chk("stress_wmask", 64'(wmask), 64'hC);
    chk("stress_pending", 64'(we_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
